rf_2p_arb: RTL and testbench



---
 rtl/rf_2p_arb.sv | 130 +++++++++++++
 tb/tb_rf_2p_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_2p_arb.sv
// Round-robin arbiter/sequencer for a 1R/1W register file: two readers share port A, two writers share port B.
// Optional same-address read-after-write bypass is enabled by defining RF_2P_ARB_BYPASS_EN.
module rf_2p_arb #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr0_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr1_i,
    output logic [1:0]            rd_gnt_o,
    output logic                  rd_vld_o,
    output logic                  rd_id_o,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    input  logic [1:0]            wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr0_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr1_i,
    input  logic [WORD_WIDTH-1:0] wr_data0_i,
    input  logic [WORD_WIDTH-1:0] wr_data1_i,
    output logic [1:0]            wr_gnt_o,
    output logic                  cena_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    input  logic [WORD_WIDTH-1:0] dataa_i,
    output logic                  cenb_o,
    output logic                  wenb_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    output logic [WORD_WIDTH-1:0] datab_o
);

    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            rd_gnt;
    logic [1:0]            wr_gnt;
    logic                  rd_vld_q;
    logic                  rd_id_q;
    logic [WORD_WIDTH-1:0] rd_hold_q;
    logic [WORD_WIDTH-1:0] rd_sel;

    function automatic logic [1:0] arb_pick(input logic [1:0] req, input logic ptr);
        if (req == 2'b11)
            return ptr ? 2'b10 : 2'b01;
        return req;
    endfunction

    // Grants are forced off while reset is held so the RF sees no access.
    always_comb begin
        rd_gnt = 2'b00;
        wr_gnt = 2'b00;
        if (!rst) begin
            rd_gnt = arb_pick(rd_req_i, rd_ptr);
            wr_gnt = arb_pick(wr_req_i, wr_ptr);
        end
    end

    assign rd_gnt_o = rd_gnt;
    assign wr_gnt_o = wr_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (|rd_gnt)
                rd_ptr <= ~rd_gnt[1];
            if (|wr_gnt)
                wr_ptr <= ~wr_gnt[1];
        end
    end

    always_comb begin
        cena_o  = ~|rd_gnt;
        addra_o = '0;
        if (rd_gnt[1])
            addra_o = rd_addr1_i;
        else if (rd_gnt[0])
            addra_o = rd_addr0_i;

        cenb_o  = ~|wr_gnt;
        addrb_o = '0;
        datab_o = '0;
        if (wr_gnt[1]) begin
            addrb_o = wr_addr1_i;
            datab_o = wr_data1_i;
        end else if (wr_gnt[0]) begin
            addrb_o = wr_addr0_i;
            datab_o = wr_data0_i;
        end
    end

    assign wenb_o = cenb_o;

`ifdef RF_2P_ARB_BYPASS_EN
    logic                  byp_flag_q;
    logic [WORD_WIDTH-1:0] byp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_flag_q <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_flag_q <= (|rd_gnt) && (|wr_gnt) && (addra_o == addrb_o);
            byp_data_q <= datab_o;
        end
    end

    assign rd_sel = byp_flag_q ? byp_data_q : dataa_i;
`else
    assign rd_sel = dataa_i;
`endif

    // Response data holds its last value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_id_q   <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            rd_vld_q  <= |rd_gnt;
            if (|rd_gnt)
                rd_id_q <= rd_gnt[1];
            rd_hold_q <= rd_data_o;
        end
    end

    assign rd_vld_o  = rd_vld_q;
    assign rd_id_o   = rd_id_q;
    assign rd_data_o = rd_vld_q ? rd_sel : rd_hold_q;

endmodule

// File: tb/tb_rf_2p_arb.sv
// Self-checking bench for rf_2p_arb: behavioural RF attached to the ports,
// plus a reference model of the arbitration and read-response rules.
module tb_rf_2p_arb;
    localparam int W = 32;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   rd_req = '0;
    logic [A-1:0] rd_addr0 = '0, rd_addr1 = '0;
    logic [1:0]   rd_gnt;
    logic         rd_vld, rd_id;
    logic [W-1:0] rd_data;
    logic [1:0]   wr_req = '0;
    logic [A-1:0] wr_addr0 = '0, wr_addr1 = '0;
    logic [W-1:0] wr_data0 = '0, wr_data1 = '0;
    logic [1:0]   wr_gnt;
    logic         cena, cenb, wenb;
    logic [A-1:0] addra, addrb;
    logic [W-1:0] dataa, datab;

    int n_checks = 0;
    int n_errors = 0;

    rf_2p_arb #(.WORD_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req), .rd_addr0_i(rd_addr0), .rd_addr1_i(rd_addr1),
        .rd_gnt_o(rd_gnt), .rd_vld_o(rd_vld), .rd_id_o(rd_id), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr0_i(wr_addr0), .wr_addr1_i(wr_addr1),
        .wr_data0_i(wr_data0), .wr_data1_i(wr_data1), .wr_gnt_o(wr_gnt),
        .cena_o(cena), .addra_o(addra), .dataa_i(dataa),
        .cenb_o(cenb), .wenb_o(wenb), .addrb_o(addrb), .datab_o(datab)
    );

    always #5 clk = ~clk;

    // Behavioural register file with registered read data.
    logic         rf_init = 1'b1;
    logic [W-1:0] rf_mem [0:(1<<A)-1];
    logic [W-1:0] rf_q;
    assign dataa = rf_q;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < (1<<A); i++) rf_mem[i] <= '0;
        end else if (!cenb) begin
            rf_mem[addrb] <= datab;
        end
        if (!cena) rf_q <= rf_mem[addra];
    end

    // Reference model state
    logic [W-1:0] ref_mem [0:(1<<A)-1];
    logic         m_rd_pref = 1'b0, m_wr_pref = 1'b0;
    logic         exp_vld = 1'b0, exp_id = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic [1:0]   last_rd_g = '0, last_wr_g = '0;

    function automatic logic [1:0] pick(input logic [1:0] req, input logic pref);
        if (req == 2'b11) return pref ? 2'b10 : 2'b01;
        return req;
    endfunction

    function automatic logic [1:0] exp_rd_gnt();
        return rst ? 2'b00 : pick(rd_req, m_rd_pref);
    endfunction

    function automatic logic [1:0] exp_wr_gnt();
        return rst ? 2'b00 : pick(wr_req, m_wr_pref);
    endfunction

    task automatic tick();
        logic [1:0]   gr, gw;
        logic [A-1:0] ra, wa;
        logic [W-1:0] wd;
        gr = exp_rd_gnt();
        gw = exp_wr_gnt();
        ra = gr[1] ? rd_addr1 : rd_addr0;
        wa = gw[1] ? wr_addr1 : wr_addr0;
        wd = gw[1] ? wr_data1 : wr_data0;
        @(posedge clk);
        if (rst) begin
            exp_vld = 1'b0; exp_id = 1'b0; exp_data = '0;
            m_rd_pref = 1'b0; m_wr_pref = 1'b0;
        end else begin
            if (gr != 2'b00) begin
                exp_vld  = 1'b1;
                exp_id   = gr[1];
                exp_data = ref_mem[ra];
`ifdef RF_2P_ARB_BYPASS_EN
                if (gw != 2'b00 && wa == ra) exp_data = wd;
`endif
                m_rd_pref = ~gr[1];
            end else begin
                exp_vld = 1'b0;
            end
            if (gw != 2'b00) begin
                ref_mem[wa] = wd;
                m_wr_pref   = ~gw[1];
            end
        end
        last_rd_g = gr;
        last_wr_g = gw;
        #1;
    endtask

    task automatic test_reset();
        rd_req = 2'b11; rd_addr0 = 8'h12; rd_addr1 = 8'h34;
        wr_req = 2'b11; wr_addr0 = 8'h56; wr_addr1 = 8'h78;
        wr_data0 = 32'h1; wr_data1 = 32'h2;
        #1;
        n_checks++;
        if ({rd_gnt, wr_gnt} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_gnt: got %b want 0000", {rd_gnt, wr_gnt});
        end
        n_checks++;
        if ({cena, cenb, wenb} !== 3'b111) begin
            n_errors++; $display("FAIL reset_cen: got %b want 111", {cena, cenb, wenb});
        end
        n_checks++;
        if ({addra, addrb, datab} !== '0) begin
            n_errors++; $display("FAIL reset_bus: addra=%h addrb=%h datab=%h want 0", addra, addrb, datab);
        end
        n_checks++;
        if ({rd_vld, rd_id, rd_data} !== '0) begin
            n_errors++; $display("FAIL reset_resp: vld=%b id=%b data=%h want 0", rd_vld, rd_id, rd_data);
        end
        tick(); tick();
        rf_init = 1'b0;
        rst = 1'b0;
        rd_req = 2'b00; wr_req = 2'b00;
        tick();
        // Read burst, then reset asserted between edges
        rd_req = 2'b11; rd_addr0 = 8'h03; rd_addr1 = 8'h04;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        exp_vld = 1'b0; exp_id = 1'b0; exp_data = '0; m_rd_pref = 1'b0; m_wr_pref = 1'b0;
        #1;
        n_checks++;
        if ({rd_vld, rd_gnt, wr_gnt} !== 5'b0) begin
            n_errors++; $display("FAIL midrst_out: vld=%b rd_gnt=%b wr_gnt=%b want 0", rd_vld, rd_gnt, wr_gnt);
        end
        n_checks++;
        if ({cena, cenb, wenb} !== 3'b111) begin
            n_errors++; $display("FAIL midrst_cen: got %b want 111", {cena, cenb, wenb});
        end
        tick();
        rst = 1'b0;
        wr_req = 2'b11; wr_addr0 = 8'h80; wr_addr1 = 8'h81; wr_data0 = 32'h5; wr_data1 = 32'h6;
        #1;
        n_checks++;
        if ({rd_gnt, wr_gnt} !== 4'b0101) begin
            n_errors++; $display("FAIL postrst_ptr: got %b want 0101", {rd_gnt, wr_gnt});
        end
        n_checks++;
        if (rd_vld !== 1'b0) begin
            n_errors++; $display("FAIL postrst_vld: got %b want 0", rd_vld);
        end
        tick();
        rd_req = 2'b00; wr_req = 2'b00;
        tick();
    endtask

    task automatic test_write_read();
        wr_req = 2'b10; wr_addr1 = 8'h10; wr_data1 = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({wr_gnt, cenb, wenb, addrb, datab} !== {2'b10, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL wr_port: gnt=%b cenb=%b wenb=%b addrb=%h datab=%h", wr_gnt, cenb, wenb, addrb, datab);
        end
        tick();
        wr_req = 2'b00;
        tick();
        rd_req = 2'b01; rd_addr0 = 8'h10;
        #1;
        n_checks++;
        if ({rd_gnt, cena, addra} !== {2'b01, 1'b0, 8'h10}) begin
            n_errors++; $display("FAIL rd_port: gnt=%b cena=%b addra=%h", rd_gnt, cena, addra);
        end
        tick();
        rd_req = 2'b00;
        n_checks++;
        if ({rd_vld, rd_id, rd_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL wr_rd_resp: vld=%b id=%b data=%h want 1 0 deadbeef", rd_vld, rd_id, rd_data);
        end
        tick();
        n_checks++;
        if ({rd_vld, rd_data} !== {1'b0, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL rd_hold: vld=%b data=%h want 0 deadbeef", rd_vld, rd_data);
        end
    endtask

    task automatic test_read_fairness();
        logic [1:0] prev_g;
        logic       prev_id;
        rd_req = 2'b11; rd_addr0 = 8'h10; rd_addr1 = 8'h11;
        prev_g = 2'b00; prev_id = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (rd_gnt !== exp_rd_gnt() || (i > 0 && rd_gnt === prev_g)) begin
                n_errors++; $display("FAIL fair_gnt[%0d]: got %b want %b prev %b", i, rd_gnt, exp_rd_gnt(), prev_g);
            end
            prev_g = rd_gnt;
            tick();
            n_checks++;
            if ({rd_vld, rd_id, rd_data} !== {1'b1, exp_id, exp_data} || (i > 0 && rd_id === prev_id)) begin
                n_errors++; $display("FAIL fair_resp[%0d]: vld=%b id=%b data=%h want 1 %b %h", i, rd_vld, rd_id, rd_data, exp_id, exp_data);
            end
            prev_id = rd_id;
        end
        rd_req = 2'b00;
        tick();
    endtask

    task automatic test_write_contention();
        logic [1:0] prev_g;
        wr_req = 2'b11; wr_addr0 = 8'h00; wr_addr1 = 8'h01; wr_data0 = 32'hA; wr_data1 = 32'hB;
        prev_g = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (wr_gnt !== exp_wr_gnt() || $countones(wr_gnt) != 1 || (i > 0 && wr_gnt === prev_g)) begin
                n_errors++; $display("FAIL wr_cont[%0d]: got %b want %b", i, wr_gnt, exp_wr_gnt());
            end
            prev_g = wr_gnt;
            tick();
        end
        wr_req = 2'b00;
        rd_req = 2'b01; rd_addr0 = 8'h00;
        tick();
        n_checks++;
        if (rd_data !== 32'hA) begin
            n_errors++; $display("FAIL wr_cont_rd0: got %h want a", rd_data);
        end
        rd_req = 2'b10; rd_addr1 = 8'h01;
        tick();
        rd_req = 2'b00;
        n_checks++;
        if ({rd_id, rd_data} !== {1'b1, 32'hB}) begin
            n_errors++; $display("FAIL wr_cont_rd1: id=%b data=%h want 1 b", rd_id, rd_data);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [W-1:0] want;
`ifdef RF_2P_ARB_BYPASS_EN
        want = 32'h2222;
`else
        want = 32'h1111;
`endif
        wr_req = 2'b01; wr_addr0 = 8'h20; wr_data0 = 32'h1111;
        tick();
        rd_req = 2'b01; rd_addr0 = 8'h20; wr_data0 = 32'h2222;
        tick();
        rd_req = 2'b00; wr_req = 2'b00;
        n_checks++;
        if ({rd_vld, rd_data} !== {1'b1, want} || rd_data !== exp_data) begin
            n_errors++; $display("FAIL collision: data=%h want %h", rd_data, want);
        end
        rd_req = 2'b10; rd_addr1 = 8'h20;
        tick();
        rd_req = 2'b00;
        n_checks++;
        if (rd_data !== 32'h2222) begin
            n_errors++; $display("FAIL collision_after: data=%h want 2222", rd_data);
        end
        tick();
    endtask

    task automatic test_wrap();
        wr_req = 2'b01; wr_addr0 = 8'hFF; wr_data0 = 32'hCAFEF00D;
        tick();
        wr_req = 2'b00;
        rd_req = 2'b01; rd_addr0 = 8'hFF;
        #1;
        n_checks++;
        if (addra !== 8'hFF) begin
            n_errors++; $display("FAIL wrap_addr: got %h want ff", addra);
        end
        tick();
        n_checks++;
        if (rd_data !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL wrap_rd: got %h want cafef00d", rd_data);
        end
        rd_addr0 = 8'h00;
        tick();
        rd_req = 2'b00;
        n_checks++;
        if (rd_data !== 32'hA) begin
            n_errors++; $display("FAIL wrap_zero: got %h want a", rd_data);
        end
        tick();
    endtask

    function automatic logic [A-1:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [1:0]   gr, gw;
        logic [A-1:0] ea, eb;
        logic [W-1:0] ed;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (last_rd_g[k] || !rd_req[k]) begin
                    rd_req[k] = ($urandom_range(0, 3) != 0);
                    if (k == 0) rd_addr0 = rand_addr(); else rd_addr1 = rand_addr();
                end
                if (last_wr_g[k] || !wr_req[k]) begin
                    wr_req[k] = ($urandom_range(0, 3) != 0);
                    if (k == 0) begin wr_addr0 = rand_addr(); wr_data0 = $urandom; end
                    else begin wr_addr1 = rand_addr(); wr_data1 = $urandom; end
                end
            end
            #1;
            gr = exp_rd_gnt();
            gw = exp_wr_gnt();
            ea = gr[1] ? rd_addr1 : (gr[0] ? rd_addr0 : '0);
            eb = gw[1] ? wr_addr1 : (gw[0] ? wr_addr0 : '0);
            ed = gw[1] ? wr_data1 : (gw[0] ? wr_data0 : '0);
            n_checks++;
            if ({rd_gnt, wr_gnt} !== {gr, gw}) begin
                n_errors++; $display("FAIL rnd_gnt[%0d]: got %b %b want %b %b", i, rd_gnt, wr_gnt, gr, gw);
            end
            n_checks++;
            if ({cena, addra, cenb, wenb, addrb, datab} !== {gr == 2'b00, ea, gw == 2'b00, gw == 2'b00, eb, ed}) begin
                n_errors++; $display("FAIL rnd_port[%0d]: cena=%b addra=%h cenb=%b wenb=%b addrb=%h datab=%h", i, cena, addra, cenb, wenb, addrb, datab);
            end
            tick();
            n_checks++;
            if (rd_vld !== exp_vld || rd_data !== exp_data || (exp_vld && rd_id !== exp_id)) begin
                n_errors++; $display("FAIL rnd_resp[%0d]: vld=%b id=%b data=%h want %b %b %h", i, rd_vld, rd_id, rd_data, exp_vld, exp_id, exp_data);
            end
        end
        rd_req = 2'b00; wr_req = 2'b00;
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1<<A); i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_read_fairness();
        test_write_contention();
        test_collision();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
